fb_write_arbiter: RTL

Responder side of the frame-buffer draw-source write protocol. It runs once per frame: it grants the shared write bus to each draw source in ascending order of source ID and translates accepted pixel writes into linear-address writes to a double-buffered pixel RAM. Once every source has finished, it swaps the display bank on the next `frame` pulse. It sits between the draw units (background, starfield, ...) and the pixel RAM; the VGA/LCD read path reads `display_bank`.

---
 rtl/fb_write_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/fb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fb_write_arbiter
// Brief    : Per-frame write-bus arbiter for draw sources; maps accepted pixels
//            to linear addresses in the draw bank of a double-buffered RAM.
// Revision : 1.0 - initial release
// ============================================================================
module fb_write_arbiter #(
    parameter int MAX_WRITE_SOURCE = 1,
    parameter int COLOR_DEPTH      = 9,
    parameter int H_RES            = 640,
    parameter int V_RES            = 480,
    parameter int BANK_ADDR_WIDTH  = 19,
    parameter int TIMEOUT_CYCLES   = 65535
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       frame,
    input  logic                       write_active,
    input  logic                       write_done,
    input  logic [31:0]                write_x_addr,
    input  logic [31:0]                write_y_addr,
    input  logic [COLOR_DEPTH-1:0]     write_color_data,
    input  logic                       write_transparent,
    output logic                       write_awaited,
    output logic [((MAX_WRITE_SOURCE > 0) ? $clog2(MAX_WRITE_SOURCE + 1) : 1)-1:0] write_source_sel,
    output logic                       mem_we,
    output logic [BANK_ADDR_WIDTH:0]   mem_addr,
    output logic [COLOR_DEPTH-1:0]     mem_data,
    output logic                       display_bank,
    output logic                       overrun,
    output logic                       timeout
);

    localparam int SEL_W = (MAX_WRITE_SOURCE > 0) ? $clog2(MAX_WRITE_SOURCE + 1) : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [31:0]                X_LIM    = 32'(H_RES);
    localparam logic [31:0]                Y_LIM    = 32'(V_RES);
    localparam logic [BANK_ADDR_WIDTH-1:0] H_RES_C  = BANK_ADDR_WIDTH'(H_RES);
    localparam logic [SEL_W-1:0]           SEL_LAST = SEL_W'(MAX_WRITE_SOURCE);
    localparam logic [CNT_W-1:0]           CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SERVE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic                       awaited_q, awaited_d;
    logic [SEL_W-1:0]           sel_q, sel_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       we_q, we_d;
    logic [BANK_ADDR_WIDTH:0]   addr_q, addr_d;
    logic [COLOR_DEPTH-1:0]     data_q, data_d;
    logic                       bank_q, bank_d;
    logic                       overrun_q, overrun_d;
    logic                       timeout_q, timeout_d;

    logic                       w_accept;
    logic                       w_cnt_hit;
    logic                       w_advance;
    logic [BANK_ADDR_WIDTH-1:0] w_lin;

    // Truncating operands to the bank width gives the same low bits as the
    // full-width product, and keeps the constant multiply to one short stage.
    assign w_lin = write_y_addr[BANK_ADDR_WIDTH-1:0] * H_RES_C
                 + write_x_addr[BANK_ADDR_WIDTH-1:0];

    assign w_accept  = awaited_q && write_active && !write_transparent &&
                       (write_x_addr < X_LIM) && (write_y_addr < Y_LIM);
    assign w_cnt_hit = (cnt_q == CNT_LAST);
    assign w_advance = awaited_q && (write_done || w_cnt_hit);

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        bank_d    = bank_q;
        overrun_d = overrun_q;
        timeout_d = timeout_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (frame) begin
                    sel_d   = '0;
                    state_d = S_SERVE;
                end
            end
            S_SERVE: begin
                if (frame) begin
                    overrun_d = 1'b1;
                end
                if (w_advance) begin
                    cnt_d = '0;
                    if (w_cnt_hit && !write_done) begin
                        timeout_d = 1'b1;
                    end
                    if (sel_q == SEL_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        sel_d = sel_q + SEL_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                cnt_d = '0;
                if (frame) begin
                    bank_d  = ~bank_q;
                    sel_d   = '0;
                    state_d = S_SERVE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        awaited_d = (state_d == S_SERVE);

        we_d   = w_accept;
        addr_d = addr_q;
        data_d = data_q;
        if (w_accept) begin
            addr_d = {~bank_q, w_lin};
            data_d = write_color_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            awaited_q <= 1'b0;
            sel_q     <= '0;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            bank_q    <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            awaited_q <= awaited_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            bank_q    <= bank_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
        end
    end

    assign write_awaited    = awaited_q;
    assign write_source_sel = sel_q;
    assign mem_we           = we_q;
    assign mem_addr         = addr_q;
    assign mem_data         = data_q;
    assign display_bank     = bank_q;
    assign overrun          = overrun_q;
    assign timeout          = timeout_q;

endmodule
`default_nettype wire
